// File: rtl/os_result_writer.sv
// os_result_writer
// Write-side address/enable generator for draining an output-stationary
// systolic array into N output BRAM banks. Lane 0 owns the linear address
// counter; every further lane inherits the address and enable of the lane
// before it one cycle later, reproducing the array's diagonal skew, so bank x
// receives lane x at addresses 0..T-1.
//
// Optional feature macro: OS_WR_CHECK_EN
//   defined   : a sticky skew checker compares in_valid_i[x] (x >= 1) with the
//               enable pipeline while busy and raises err_o on any mismatch.
//   undefined : err_o is tied low and no checker logic exists.

module os_result_writer #(
    parameter int D_W = 8,
    parameter int N   = 3,
    parameter int M   = 6,
    localparam int T  = (M * M) / N,
    localparam int AW = (T > 1) ? $clog2(T) : 1,
    localparam int FW = (N > 1) ? $clog2(N) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic [N-1:0][D_W-1:0]    in_data_i,
    input  logic [N-1:0]             in_valid_i,
    output logic [N-1:0][AW-1:0]     wr_addr_bram_o,
    output logic [N-1:0][D_W-1:0]    wr_data_bram_o,
    output logic [N-1:0]             wr_en_bram_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       cnt_q, cnt_d;
    logic [FW-1:0]       fcnt_q, fcnt_d;

    logic [N-1:0]           en_q;
    logic [N-1:0][AW-1:0]   addr_q;
    logic [N-1:0][D_W-1:0]  data_q;

    // State, word counter and flush counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // Next-state logic: the word counter advances only on accepted lane-0
    // words and holds at T-1 on the last one, so it never wraps within a
    // drain; the flush counter lets the skewed lanes finish before DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fcnt_d  = fcnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end
            end
            S_DRAIN: begin
                if (in_valid_i[0]) begin
                    if (cnt_q == AW'(T - 1)) begin
                        state_d = S_FLUSH;
                        fcnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end
            end
            S_FLUSH: begin
                if (fcnt_q == FW'(N - 1)) begin
                    state_d = S_DONE;
                end else begin
                    fcnt_d = fcnt_q + FW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Lane stage registers: lane 0 samples the counter, later lanes shift the
    // enable/address diagonally while taking their own data straight from
    // the array, so a lane-0 stall bubble ripples down without a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q   <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            en_q[0]   <= (state_q == S_DRAIN) && in_valid_i[0];
            addr_q[0] <= cnt_q;
            data_q[0] <= in_data_i[0];
            for (int x = 1; x < N; x++) begin
                en_q[x]   <= en_q[x-1];
                addr_q[x] <= addr_q[x-1];
                data_q[x] <= in_data_i[x];
            end
        end
    end

    assign wr_en_bram_o   = en_q;
    assign wr_addr_bram_o = addr_q;
    assign wr_data_bram_o = data_q;
    assign busy_o         = (state_q != S_IDLE);
    assign done_o         = (state_q == S_DONE);

`ifdef OS_WR_CHECK_EN
    logic err_q, err_d;
    logic skewMismatch;

    // Skew checker: each lane x >= 1 must present valid exactly when the
    // enable of lane x-1 is set; any disagreement while busy is latched
    // until the next accepted start.
    always_comb begin
        skewMismatch = 1'b0;
        for (int x = 1; x < N; x++) begin
            if (in_valid_i[x] != en_q[x-1]) begin
                skewMismatch = 1'b1;
            end
        end
        err_d = err_q;
        if ((state_q == S_IDLE) && start_i) begin
            err_d = 1'b0;
        end else if (busy_o && skewMismatch) begin
            err_d = 1'b1;
        end
    end

    // Sticky error flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    logic unused_valid;

    assign unused_valid = ^in_valid_i;
    assign err_o        = 1'b0;
`endif

endmodule
